serial_adder: RTL and testbench

Bit-serial N-bit adder built around a single full-adder slice, the `Full_adder` module with ports A, B, Cin, Sum, Carry. It adds one bit per clock, LSB first, and keeps the ripple carry in a flip-flop between cycles. It sits directly upstream of the full-adder cell: it latches two parallel operands, feeds the slice one bit pair per cycle, and collects the sum bits into a parallel result. A start/busy/done handshake connects it to the surrounding datapath.

---
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice processes one operand bit per clock,
// LSB first, with the ripple carry held in a flip-flop between cycles.

module Full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Carry
);
  assign Sum   = A ^ B ^ Cin;
  assign Carry = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] sha, shb, shr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_carry;
  logic             last_bit;

  Full_adder u_fa (
    .A     (sha[0]),
    .B     (shb[0]),
    .Cin   (carry),
    .Sum   (fa_sum),
    .Carry (fa_carry)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_bit) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Both handshake outputs decode the state register, so neither is combinational from start.
  assign busy = (state == RUN);
  assign done = (state == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sha   <= '0;
      shb   <= '0;
      shr   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sha   <= A;
            shb   <= B;
            carry <= Cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          sha   <= sha >> 1;
          shb   <= shb >> 1;
          shr   <= {fa_sum, shr[WIDTH-1:1]};
          carry <= fa_carry;
          cnt   <= cnt + CW'(1);
          // The final slice output is folded straight into Sum so it lands on the edge entering FIN.
          if (last_bit) begin
            Sum  <= {fa_sum, shr[WIDTH-1:1]};
            Cout <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes A+B+Cin into a queue,
// a negedge monitor pops on every done and also polices busy length and result hold.

module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .Cin   (cin),
    .busy  (busy),
    .done  (done),
    .Sum   (sum),
    .Cout  (cout)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         edges = 0;
  int         free_at = 0;
  int         run_len = 0;
  int         last_done = -1;
  bit         prev_busy = 1'b0;
  bit         cont_mode = 1'b0;
  logic [W:0] expq[$];
  logic [W:0] last_exp = '0;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, edges);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [W:0] e;
    if (rst) begin
      chk("reset_state", int'({busy, done, cout, sum}), 0);
      run_len   = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) run_len++;
      else if (prev_busy) begin
        chk("busy_len", run_len, W);
        run_len = 0;
      end
      prev_busy = busy;
      if (done) begin
        chk("busy_at_done", int'(busy), 0);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with Sum=0x%0h Cout=%0d, expected no done", sum, cout);
        end else begin
          e = expq.pop_front();
          chk("result", int'({cout, sum}), int'(e));
          last_exp = e;
        end
        if (cont_mode && last_done >= 0) chk("done_spacing", edges - last_done, W + 2);
        last_done = edges;
      end else begin
        chk("hold", int'({cout, sum}), int'(last_exp));
      end
    end
  end

  // Drives one request at the earliest edge the adder can accept it.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit hold);
    while (edges + 1 < free_at) begin
      @(posedge clk); #1;
    end
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    expq.push_back({1'b0, x} + {1'b0, y} + {{W{1'b0}}, c});
    free_at = edges + 1 + W + 2;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", expq.size());
      expq.delete();
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    idle_cycles(3);
    rst = 1'b0;
    free_at = edges + 1;
    idle_cycles(5);

    issue(8'h5A, 8'h3C, 1'b0, 1'b0);
    drain();
    idle_cycles(4);

    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1, 1'b0);
    issue(8'h00, 8'h00, 1'b1, 1'b0);
    drain();

    // start pulsed mid-RUN must be ignored
    issue(8'h10, 8'h20, 1'b0, 1'b0);
    idle_cycles(2);
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'hAA;
    idle_cycles(1);
    start = 1'b0;
    a     = 8'h55;
    b     = 8'h11;
    drain();
    idle_cycles(W + 4);

    cont_mode = 1'b1;
    last_done = -1;
    for (int i = 0; i < 4; i++) issue(W'($urandom), W'($urandom), 1'($urandom), i < 3);
    drain();
    start = 1'b0;
    cont_mode = 1'b0;
    idle_cycles(3);

    // reset in the middle of an addition: no done, outputs cleared
    issue(8'h5A, 8'h3C, 1'b0, 1'b0);
    idle_cycles(3);
    rst = 1'b1;
    expq.delete();
    last_exp = '0;
    idle_cycles(2);
    rst = 1'b0;
    free_at = edges + 1;
    idle_cycles(W + 4);
    issue(8'h01, 8'h02, 1'b1, 1'b0);
    drain();

    for (int i = 0; i < 1000; i++) issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    drain();
    idle_cycles(W + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
